// File: rtl/selftrigger_frame_capture.sv
// Self-trigger frame capture: keeps a circular pre-trigger history and, on an accepted
// trigger, emits a frame of 4 timestamp words plus FRAME_LEN samples over valid/ready.
module selftrigger_frame_capture #(
    parameter int PRE_SAMPLES = 64,
    parameter int FRAME_LEN   = 512,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] x,
    input  logic        trigger,
    input  logic [63:0] timestamp,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_first,
    output logic        m_last,
    output logic        busy,
    output logic [15:0] dropped_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  PRE_CNT   = CNT_W'(PRE_SAMPLES);
    localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'(FRAME_LEN - PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] HDR_OFS   = ADDR_W'(4);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  HDR_WORDS = IDX_W'(4);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN + 3);

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic [63:0]       ts_q, ts_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              loaded_all_q, loaded_all_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_first_q, m_first_d;
    logic              m_last_q, m_last_d;
    logic              busy_q, busy_d;
    logic [15:0]       dropped_q, dropped_d;

    logic [15:0]       ring_mem [DEPTH];
    logic              trig_s, xfer_s, wr_en_s, load_s, drop_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [15:0]       hdr_word_s;

    // Next-state logic: ring writes, capture sequencing and the output word register.
    always_comb begin
        trig_s       = enable && trigger;
        xfer_s       = m_valid_q && m_ready;
        wr_en_s      = enable && (state_q != ST_READOUT) && !reset;
        load_s       = (state_q == ST_READOUT) && !loaded_all_q && (!m_valid_q || m_ready);
        rd_addr_s    = start_addr_q + out_idx_q[ADDR_W-1:0] - HDR_OFS;
        drop_s       = 1'b0;

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_addr_d = start_addr_q;
        fill_d       = fill_q;
        post_d       = post_q;
        ts_d         = ts_q;
        out_idx_d    = out_idx_q;
        loaded_all_d = loaded_all_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_first_d    = m_first_q;
        m_last_d     = m_last_q;

        case (out_idx_q[1:0])
            2'd0:    hdr_word_s = ts_q[63:48];
            2'd1:    hdr_word_s = ts_q[47:32];
            2'd2:    hdr_word_s = ts_q[31:16];
            default: hdr_word_s = ts_q[15:0];
        endcase

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // The output register reloads whenever it is empty or its word is being taken.
        if (load_s) begin
            m_valid_d    = 1'b1;
            m_first_d    = (out_idx_q == '0);
            m_last_d     = (out_idx_q == LAST_IDX);
            m_data_d     = (out_idx_q < HDR_WORDS) ? hdr_word_s : ring_mem[rd_addr_s];
            loaded_all_d = (out_idx_q == LAST_IDX);
            out_idx_d    = out_idx_q + IDX_ONE;
        end else if (xfer_s) begin
            m_valid_d = 1'b0;
            m_first_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_ARMING: begin
                drop_s = trig_s;
                if (enable) begin
                    fill_d = fill_q + CNT_ONE;
                    if (fill_d == PRE_CNT) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_ARMING;
                    end
                end else begin
                    fill_d = fill_q;
                end
            end
            ST_ARMED: begin
                if (trig_s) begin
                    start_addr_d = wr_ptr_q - PRE_OFS;
                    ts_d         = timestamp;
                    post_d       = POST_LOAD;
                    state_d      = ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                drop_s = trig_s;
                if (enable) begin
                    if (post_q == '0) begin
                        state_d      = ST_READOUT;
                        out_idx_d    = '0;
                        loaded_all_d = 1'b0;
                    end else begin
                        post_d = post_q - CNT_ONE;
                    end
                end else begin
                    post_d = post_q;
                end
            end
            ST_READOUT: begin
                drop_s = trig_s;
                if (xfer_s && m_last_q) begin
                    state_d      = ST_ARMING;
                    fill_d       = '0;
                    out_idx_d    = '0;
                    loaded_all_d = 1'b0;
                end else begin
                    state_d = ST_READOUT;
                end
            end
            default: begin
                state_d = ST_ARMING;
            end
        endcase

        if (drop_s && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end else begin
            dropped_d = dropped_q;
        end

        busy_d = (state_d == ST_CAPTURE) || (state_d == ST_READOUT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARMING;
            wr_ptr_q     <= '0;
            start_addr_q <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            ts_q         <= 64'd0;
            out_idx_q    <= '0;
            loaded_all_q <= 1'b0;
            m_data_q     <= 16'd0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_addr_q <= start_addr_d;
            fill_q       <= fill_d;
            post_q       <= post_d;
            ts_q         <= ts_d;
            out_idx_q    <= out_idx_d;
            loaded_all_q <= loaded_all_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            dropped_q    <= dropped_d;
        end
    end

    // Ring buffer storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ring_mem[wr_ptr_q] <= x;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_first       = m_first_q;
    assign m_last        = m_last_q;
    assign busy          = busy_q;
    assign dropped_count = dropped_q;
endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// Randomised bench for selftrigger_frame_capture against a frame-level reference model.
module tb_selftrigger_frame_capture;
    localparam int PRE = 8;
    localparam int LEN = 32;
    localparam int AW  = 6;
    localparam int P_ARMING = 0, P_ARMED = 1, P_CAPTURE = 2, P_READOUT = 3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] x;
    logic        trigger;
    logic [63:0] timestamp;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;
    logic        busy;
    logic [15:0] dropped_count;

    selftrigger_frame_capture #(.PRE_SAMPLES(PRE), .FRAME_LEN(LEN), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .trigger(trigger),
        .timestamp(timestamp), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_first(m_first), .m_last(m_last), .busy(busy), .dropped_count(dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: phase, history of written samples, frame being assembled
    int          phase;
    int          drops;
    logic [15:0] hist[$];
    logic [15:0] frame[$];
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    int          obs_cyc[$];
    int          stall_err, valid_err, busy_err, drop_err;
    int          ro_wait, ro_wait_max;
    bit          ro_started;
    bit          prev_stall;
    logic [17:0] prev_word;
    int          cyc = 0;
    int          samp_n = 0;
    bit          x_ramp;
    bit          ts_run;
    logic [63:0] ts_val;

    function automatic logic rdy_of(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            default: return ($urandom_range(0, 99) < 60);
        endcase
    endfunction

    // One clock: drive inputs at negedge, observe outputs, advance the model.
    task automatic step(input logic rst, input logic en, input logic [15:0] xv,
                        input logic trg, input logic rdy, input logic [63:0] ts);
        logic [17:0] cur;
        bit xfer;
        @(negedge clk);
        reset = rst; enable = en; x = xv; trigger = trg; m_ready = rdy; timestamp = ts;
        cyc++;
        cur = {m_first, m_last, m_data};
        if (prev_stall && !(m_valid === 1'b1 && cur === prev_word)) stall_err++;
        if (m_valid === 1'b1 && phase != P_READOUT) valid_err++;
        if (busy !== ((phase == P_CAPTURE) || (phase == P_READOUT))) busy_err++;
        if (dropped_count !== 16'(drops)) drop_err++;
        if (phase == P_READOUT && !ro_started) begin
            if (m_valid === 1'b1) ro_started = 1'b1;
            else begin
                ro_wait++;
                if (ro_wait > ro_wait_max) ro_wait_max = ro_wait;
            end
        end
        prev_stall = !rst && (m_valid === 1'b1) && !rdy;
        prev_word = cur;
        xfer = !rst && (m_valid === 1'b1) && rdy;
        if (xfer) begin
            obs_q.push_back(cur);
            obs_cyc.push_back(cyc);
        end
        if (rst) begin
            phase = P_ARMING; drops = 0; hist.delete(); frame.delete();
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else begin
            case (phase)
                P_ARMING: if (en) begin
                    if (trg && drops < 65535) drops++;
                    hist.push_back(xv);
                    if (hist.size() >= PRE) phase = P_ARMED;
                end
                P_ARMED: if (en) begin
                    if (trg) begin
                        frame.delete();
                        foreach (hist[i]) frame.push_back(hist[i]);
                        frame.push_back(xv);
                        exp_q.push_back({2'b10, ts[63:48]});
                        exp_q.push_back({2'b00, ts[47:32]});
                        exp_q.push_back({2'b00, ts[31:16]});
                        exp_q.push_back({2'b00, ts[15:0]});
                        phase = P_CAPTURE;
                    end else begin
                        hist.push_back(xv);
                        if (hist.size() > PRE) void'(hist.pop_front());
                    end
                end
                P_CAPTURE: if (en) begin
                    if (trg && drops < 65535) drops++;
                    if (frame.size() < LEN) frame.push_back(xv);
                    else begin
                        for (int i = 0; i < LEN; i++) exp_q.push_back({1'b0, (i == LEN - 1), frame[i]});
                        phase = P_READOUT; ro_wait = 0; ro_started = 1'b0;
                    end
                end
                default: begin
                    if (en && trg && drops < 65535) drops++;
                    if (xfer && obs_q.size() == exp_q.size()) begin
                        phase = P_ARMING; hist.delete();
                    end
                end
            endcase
        end
    endtask

    task automatic tick(input logic en, input logic trg, input logic rdy);
        logic [15:0] xv;
        xv = x_ramp ? 16'(samp_n) : 16'($urandom);
        if (ts_run) ts_val = {$urandom, $urandom};
        step(1'b0, en, xv, trg, rdy, ts_val);
        if (en) samp_n++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, ts_val);
        @(posedge clk); #1;
        samp_n = 0; obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        stall_err = 0; valid_err = 0; busy_err = 0; drop_err = 0;
        ro_wait_max = 0; prev_stall = 1'b0;
    endtask

    task automatic ramp_to(input int last_n, input int t1, input int t2, input int mode);
        while (samp_n <= last_n) tick(1'b1, (samp_n == t1) || (samp_n == t2), rdy_of(mode));
    endtask

    task automatic drain(input int mode, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (phase == P_ARMING && obs_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick(1'b1, 1'b0, rdy_of(mode));
        end
    endtask

    task automatic test_reset();
        x_ramp = 1'b1; ts_run = 1'b0; ts_val = 64'd0;
        do_reset();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_first !== 1'b0) begin n_bad++; $display("FAIL reset_first: got %b want 0", m_first); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (m_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", m_data); end
        n_cmp++; if (dropped_count !== 16'h0) begin n_bad++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
    endtask

    task automatic test_basic_frame();
        bit ok;
        logic [15:0] hdr [4];
        hdr[0] = 16'h0011; hdr[1] = 16'h2233; hdr[2] = 16'h4455; hdr[3] = 16'h6677;
        x_ramp = 1'b1; ts_run = 1'b0; ts_val = 64'h0011223344556677;
        do_reset();
        ramp_to(100, 100, -1, 0);
        drain(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done: got timeout want frame end"); end
        n_cmp++; if (obs_q.size() != 36) begin n_bad++; $display("FAIL basic_count: got %0d want 36", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== {(i == 0), 1'b0, hdr[i]}) begin n_bad++; $display("FAIL basic_hdr%0d: got %h want %h", i, obs_q[i], {(i == 0), 1'b0, hdr[i]}); end
        end
        for (int i = 0; i < LEN && i + 4 < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i + 4] !== {1'b0, (i == LEN - 1), 16'(92 + i)}) begin n_bad++; $display("FAIL basic_sample%0d: got %h want %h", i, obs_q[i + 4], {1'b0, (i == LEN - 1), 16'(92 + i)}); end
        end
        n_cmp++; if (obs_cyc.size() == 36 && obs_cyc[35] - obs_cyc[0] != 35) begin n_bad++; $display("FAIL basic_b2b: got span %0d want 35", obs_cyc[35] - obs_cyc[0]); end
        n_cmp++; if (ro_wait_max > 3) begin n_bad++; $display("FAIL basic_latency: got %0d want <=3", ro_wait_max); end
        n_cmp++; if (dropped_count !== 16'd0) begin n_bad++; $display("FAIL basic_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (busy_err != 0 || valid_err != 0) begin n_bad++; $display("FAIL basic_busy_valid: got %0d/%0d want 0/0", busy_err, valid_err); end
    endtask

    task automatic test_arming_drop();
        bit ok;
        x_ramp = 1'b1; ts_run = 1'b1;
        do_reset();
        ramp_to(10, 5, -1, 0);
        n_cmp++; if (dropped_count !== 16'd1) begin n_bad++; $display("FAIL arming_drop: got %0d want 1", dropped_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arming_busy: got %b want 0", busy); end
        ramp_to(50, 50, -1, 0);
        drain(0, ok);
        n_cmp++; if (!ok || obs_q.size() != 36) begin n_bad++; $display("FAIL arming_frame: got %0d words want 36", obs_q.size()); end
        n_cmp++; if (obs_q.size() == 36 && (obs_q[4][15:0] !== 16'd42 || obs_q[35] !== {2'b01, 16'd73})) begin n_bad++; $display("FAIL arming_samples: got %h..%h want 42..73", obs_q[4][15:0], obs_q[35][15:0]); end
        n_cmp++; if (dropped_count !== 16'd1) begin n_bad++; $display("FAIL arming_drop_end: got %0d want 1", dropped_count); end
    endtask

    task automatic test_back_to_back_triggers();
        bit ok;
        x_ramp = 1'b1; ts_run = 1'b1;
        do_reset();
        ramp_to(110, 100, 110, 0);
        for (int c = 0; c < 200 && phase != P_READOUT; c++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        drain(0, ok);
        n_cmp++; if (!ok || obs_q.size() != 36) begin n_bad++; $display("FAIL b2b_frame: got %0d words want 36", obs_q.size()); end
        n_cmp++; if (obs_q.size() == 36 && (obs_q[4][15:0] !== 16'd92 || obs_q[35][15:0] !== 16'd123)) begin n_bad++; $display("FAIL b2b_samples: got %0d..%0d want 92..123", obs_q[4][15:0], obs_q[35][15:0]); end
        n_cmp++; if (dropped_count !== 16'd2) begin n_bad++; $display("FAIL b2b_dropped: got %0d want 2", dropped_count); end
    endtask

    task automatic test_wrap_backpressure();
        bit ok;
        x_ramp = 1'b1; ts_run = 1'b1;
        do_reset();
        ramp_to(70, 70, -1, 1);
        drain(1, ok);
        n_cmp++; if (!ok || obs_q.size() != 36) begin n_bad++; $display("FAIL wrap_count: got %0d want 36", obs_q.size()); end
        for (int i = 0; i < LEN && i + 4 < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i + 4] !== {1'b0, (i == LEN - 1), 16'(62 + i)}) begin n_bad++; $display("FAIL wrap_sample%0d: got %h want %h", i, obs_q[i + 4], {1'b0, (i == LEN - 1), 16'(62 + i)}); end
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_hdr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL wrap_stall_hold: got %0d changes want 0", stall_err); end
    endtask

    task automatic test_reset_mid_readout();
        bit ok;
        x_ramp = 1'b1; ts_run = 1'b1;
        do_reset();
        ramp_to(100, 100, -1, 0);
        for (int c = 0; c < 200 && obs_q.size() < 10; c++) tick(1'b1, 1'b0, 1'b1);
        n_cmp++; if (obs_q.size() != 10) begin n_bad++; $display("FAIL midrst_prefix: got %0d want 10", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        do_reset();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
        n_cmp++; if (dropped_count !== 16'd0) begin n_bad++; $display("FAIL midrst_dropped: got %0d want 0", dropped_count); end
        ramp_to(25, 3, 20, 0);
        drain(0, ok);
        n_cmp++; if (dropped_count !== 16'd1) begin n_bad++; $display("FAIL midrst_early_drop: got %0d want 1", dropped_count); end
        n_cmp++; if (!ok || obs_q.size() != 36) begin n_bad++; $display("FAIL midrst_frame: got %0d words want 36", obs_q.size()); end
        n_cmp++; if (obs_q.size() == 36 && (obs_q[4][15:0] !== 16'd12 || obs_q[35] !== {2'b01, 16'd43})) begin n_bad++; $display("FAIL midrst_samples: got %0d..%0d want 12..43", obs_q[4][15:0], obs_q[35][15:0]); end
    endtask

    task automatic test_enable_gap();
        bit ok;
        int gap_valid;
        x_ramp = 1'b1; ts_run = 1'b1; gap_valid = 0;
        do_reset();
        ramp_to(110, 100, -1, 0);
        for (int g = 0; g < 5; g++) begin
            tick(1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
            if (m_valid !== 1'b0 || busy !== 1'b1) gap_valid++;
        end
        drain(0, ok);
        n_cmp++; if (gap_valid != 0) begin n_bad++; $display("FAIL gap_activity: got %0d bad cycles want 0", gap_valid); end
        n_cmp++; if (!ok || obs_q.size() != 36) begin n_bad++; $display("FAIL gap_count: got %0d want 36", obs_q.size()); end
        for (int i = 0; i < LEN && i + 4 < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i + 4][15:0] !== 16'(92 + i)) begin n_bad++; $display("FAIL gap_sample%0d: got %0d want %0d", i, obs_q[i + 4][15:0], 92 + i); end
        end
    endtask

    task automatic test_random_stream();
        bit ok;
        x_ramp = 1'b0; ts_run = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++)
            tick($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4, rdy_of(2));
        drain(2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_done: got timeout want frame end"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (dropped_count !== 16'(drops)) begin n_bad++; $display("FAIL rand_dropped: got %0d want %0d", dropped_count, drops); end
        n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL rand_stall_hold: got %0d want 0", stall_err); end
        n_cmp++; if (valid_err != 0) begin n_bad++; $display("FAIL rand_valid_phase: got %0d want 0", valid_err); end
        n_cmp++; if (busy_err != 0) begin n_bad++; $display("FAIL rand_busy: got %0d want 0", busy_err); end
        n_cmp++; if (drop_err != 0) begin n_bad++; $display("FAIL rand_drop_track: got %0d want 0", drop_err); end
        n_cmp++; if (ro_wait_max > 3) begin n_bad++; $display("FAIL rand_latency: got %0d want <=3", ro_wait_max); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; x = 16'h0; trigger = 1'b0; m_ready = 1'b0; timestamp = 64'd0;
        phase = P_ARMING; drops = 0; prev_stall = 1'b0; prev_word = 18'h0;
        ro_wait = 0; ro_wait_max = 0; ro_started = 1'b0;
        stall_err = 0; valid_err = 0; busy_err = 0; drop_err = 0;
        x_ramp = 1'b1; ts_run = 1'b0; ts_val = 64'd0;
        test_reset();
        test_basic_frame();
        test_arming_drop();
        test_back_to_back_triggers();
        test_wrap_backpressure();
        test_reset_mid_readout();
        test_enable_gap();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
